// File: rtl/fm_wm_pingpong_buffer.sv
// fm_wm_pingpong_buffer: two-bank FEATURE_ROWS x WEIGHT_COLS result store.
// A producer fills and commits one bank while the other bank streams out row by row.
// Build option: define FM_WM_SAT_EN for signed saturating accumulate (a clamp sets err);
// without it, accumulate wraps and overflow is not flagged.
module fm_wm_pingpong_buffer #(
    parameter int unsigned FEATURE_ROWS   = 6,
    parameter int unsigned WEIGHT_COLS    = 3,
    parameter int unsigned DOT_PROD_WIDTH = 16,
    parameter int unsigned FEATURE_WIDTH  = $clog2(FEATURE_ROWS),
    parameter int unsigned WEIGHT_WIDTH   = $clog2(WEIGHT_COLS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [FEATURE_WIDTH-1:0]  wr_row,
    input  logic [WEIGHT_WIDTH-1:0]   wr_col,
    input  logic [DOT_PROD_WIDTH-1:0] wr_data,
    input  logic                      wr_accum,
    input  logic                      wr_commit,
    output logic                      wr_ready,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [FEATURE_WIDTH-1:0]  rd_row_idx,
    output logic [DOT_PROD_WIDTH-1:0] rd_row_data [0:WEIGHT_COLS-1],
    output logic                      rd_last,
    output logic                      err
);

    localparam logic [FEATURE_WIDTH-1:0] LAST_ROW = FEATURE_WIDTH'(FEATURE_ROWS - 1);
    localparam logic [WEIGHT_WIDTH-1:0]  LAST_COL = WEIGHT_WIDTH'(WEIGHT_COLS - 1);
    localparam logic [FEATURE_WIDTH-1:0] ROW_ONE  = FEATURE_WIDTH'(1);
`ifdef FM_WM_SAT_EN
    localparam logic [DOT_PROD_WIDTH-1:0] SAT_MAX = {1'b0, {(DOT_PROD_WIDTH-1){1'b1}}};
    localparam logic [DOT_PROD_WIDTH-1:0] SAT_MIN = {1'b1, {(DOT_PROD_WIDTH-1){1'b0}}};
`endif

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } rd_state_t;

    logic [DOT_PROD_WIDTH-1:0] mem [0:1][0:FEATURE_ROWS-1][0:WEIGHT_COLS-1];
    logic [1:0]                bank_full;
    logic                      wr_bank;
    logic                      rd_bank;
    rd_state_t                 rd_state;

    logic                      wr_in_range;
    logic                      wr_accept;
    logic                      commit_accept;
    logic                      read_done;
    logic                      wr_err;
    logic                      sat_clamp;
    logic [DOT_PROD_WIDTH-1:0] cur_entry;
    logic [DOT_PROD_WIDTH-1:0] new_entry;
`ifdef FM_WM_SAT_EN
    logic [DOT_PROD_WIDTH:0]   sum_ext;
`endif

    assign wr_ready = ~bank_full[wr_bank];

    // Write-side decode: acceptance, next entry value and protocol errors.
    always_comb begin
        wr_in_range   = (wr_row <= LAST_ROW) && (wr_col <= LAST_COL);
        wr_accept     = wr_en & wr_ready & wr_in_range;
        commit_accept = wr_commit & wr_ready;
        read_done     = rd_valid & rd_ready & rd_last;
        cur_entry     = wr_in_range ? mem[wr_bank][wr_row][wr_col] : '0;
        sat_clamp     = 1'b0;
        new_entry     = wr_data;
        if (wr_accum) begin
`ifdef FM_WM_SAT_EN
            sum_ext = {cur_entry[DOT_PROD_WIDTH-1], cur_entry}
                    + {wr_data[DOT_PROD_WIDTH-1], wr_data};
            if (sum_ext[DOT_PROD_WIDTH] != sum_ext[DOT_PROD_WIDTH-1]) begin
                sat_clamp = 1'b1;
                new_entry = sum_ext[DOT_PROD_WIDTH] ? SAT_MIN : SAT_MAX;
            end else begin
                new_entry = sum_ext[DOT_PROD_WIDTH-1:0];
            end
`else
            new_entry = cur_entry + wr_data;
`endif
        end
`ifdef FM_WM_SAT_EN
        else begin
            sum_ext = '0;
        end
`endif
        wr_err = (wr_en & (~wr_ready | ~wr_in_range))
               | (wr_commit & ~wr_ready)
               | (wr_accept & wr_accum & sat_clamp);
    end

    // Bank storage, bank occupancy, write pointer and sticky error.
    // A write and a read-done clear never hit the same bank: one is EMPTY, the other FULL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < FEATURE_ROWS; r++) begin
                    for (int c = 0; c < WEIGHT_COLS; c++) begin
                        mem[1'(b)][FEATURE_WIDTH'(r)][WEIGHT_WIDTH'(c)] <= '0;
                    end
                end
            end
            bank_full <= '0;
            wr_bank   <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (wr_accept) begin
                mem[wr_bank][wr_row][wr_col] <= new_entry;
            end
            if (commit_accept) begin
                bank_full[wr_bank] <= 1'b1;
                wr_bank            <= ~wr_bank;
            end
            if (read_done) begin
                bank_full[rd_bank] <= 1'b0;
                for (int r = 0; r < FEATURE_ROWS; r++) begin
                    for (int c = 0; c < WEIGHT_COLS; c++) begin
                        mem[rd_bank][FEATURE_WIDTH'(r)][WEIGHT_WIDTH'(c)] <= '0;
                    end
                end
            end
            if (wr_err) begin
                err <= 1'b1;
            end
        end
    end

    // Read sequencer: waits for a FULL bank, then presents rows 0..FEATURE_ROWS-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state   <= IDLE;
            rd_valid   <= 1'b0;
            rd_row_idx <= '0;
            rd_last    <= 1'b0;
            rd_bank    <= 1'b0;
        end else begin
            case (rd_state)
                IDLE: begin
                    if (bank_full[rd_bank]) begin
                        rd_state   <= STREAM;
                        rd_valid   <= 1'b1;
                        rd_row_idx <= '0;
                        rd_last    <= (LAST_ROW == '0);
                    end
                end
                STREAM: begin
                    if (rd_ready) begin
                        if (rd_last) begin
                            rd_state   <= IDLE;
                            rd_valid   <= 1'b0;
                            rd_row_idx <= '0;
                            rd_last    <= 1'b0;
                            rd_bank    <= ~rd_bank;
                        end else begin
                            rd_row_idx <= rd_row_idx + ROW_ONE;
                            rd_last    <= ((rd_row_idx + ROW_ONE) == LAST_ROW);
                        end
                    end
                end
                default: begin
                    rd_state <= IDLE;
                end
            endcase
        end
    end

    // Row data comes straight from the bank flops; zero whenever no row is presented.
    always_comb begin
        for (int c = 0; c < WEIGHT_COLS; c++) begin
            rd_row_data[WEIGHT_WIDTH'(c)] = rd_valid ? mem[rd_bank][rd_row_idx][WEIGHT_WIDTH'(c)] : '0;
        end
    end

endmodule

// File: tb/tb_fm_wm_pingpong_buffer.sv
// Bench for fm_wm_pingpong_buffer: directed vector table, hand sequences for
// stalls / full banks / reset, and random traffic against a tile-queue model.
module tb_fm_wm_pingpong_buffer;

    localparam int ROWS = 6;
    localparam int COLS = 3;
    localparam int DW   = 16;
    localparam int FW   = 3;
    localparam int WW   = 2;
    localparam int N    = ROWS * COLS;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [FW-1:0] wr_row;
    logic [WW-1:0] wr_col;
    logic [DW-1:0] wr_data;
    logic          wr_accum;
    logic          wr_commit;
    logic          wr_ready;
    logic          rd_valid;
    logic          rd_ready;
    logic [FW-1:0] rd_row_idx;
    logic [DW-1:0] rd_row_data [0:COLS-1];
    logic          rd_last;
    logic          err;

    always #5 clk = ~clk;

    fm_wm_pingpong_buffer #(
        .FEATURE_ROWS  (ROWS),
        .WEIGHT_COLS   (COLS),
        .DOT_PROD_WIDTH(DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_row     (wr_row),
        .wr_col     (wr_col),
        .wr_data    (wr_data),
        .wr_accum   (wr_accum),
        .wr_commit  (wr_commit),
        .wr_ready   (wr_ready),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_row_idx (rd_row_idx),
        .rd_row_data(rd_row_data),
        .rd_last    (rd_last),
        .err        (err)
    );

    typedef struct packed {
        logic                en;
        logic [FW-1:0]       row;
        logic [WW-1:0]       col;
        logic [DW-1:0]       data;
        logic                acc;
        logic                commit;
        logic                rdy;
        logic                chk;
        logic                e_wr_ready;
        logic                e_valid;
        logic [FW-1:0]       e_idx;
        logic                e_last;
        logic [2:0][DW-1:0]  e_d;
        logic                e_err;
    } vec_t;

    int vectors    = 0;
    int miscompares = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model: the tile being built, a queue of committed tiles (flattened,
    // N entries each, row-major), and the reader's visible row.
    logic [DW-1:0] m_wt [N];
    logic [DW-1:0] m_q [$];
    bit            m_vis;
    int            m_idx;
    bit            m_err;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) m_wt[i] = '0;
        m_q.delete();
        m_vis = 1'b0;
        m_idx = 0;
        m_err = 1'b0;
    endfunction

    function automatic int tiles();
        return m_q.size() / N;
    endfunction

    function automatic void model_update(input vec_t v);
        bit ready;
        bit drain;
        bit start;
        int i;
        int s;
        ready = (tiles() < 2);
        drain = 1'b0;
        start = 1'b0;
        if (m_vis) begin
            if (v.rdy) begin
                if (m_idx == ROWS - 1) drain = 1'b1;
                else m_idx++;
            end
        end else if (tiles() > 0) begin
            start = 1'b1;
        end
        if (v.en) begin
            if (!ready || int'(v.row) >= ROWS || int'(v.col) >= COLS) begin
                m_err = 1'b1;
            end else begin
                i = int'(v.row) * COLS + int'(v.col);
                if (!v.acc) begin
                    m_wt[i] = v.data;
                end else begin
                    s = int'($signed(m_wt[i])) + int'($signed(v.data));
`ifdef FM_WM_SAT_EN
                    if (s > 32767) begin
                        s = 32767;
                        m_err = 1'b1;
                    end else if (s < -32768) begin
                        s = -32768;
                        m_err = 1'b1;
                    end
`endif
                    m_wt[i] = DW'(s);
                end
            end
        end
        if (v.commit) begin
            if (!ready) begin
                m_err = 1'b1;
            end else begin
                for (int k = 0; k < N; k++) begin
                    m_q.push_back(m_wt[k]);
                    m_wt[k] = '0;
                end
            end
        end
        if (drain) begin
            for (int k = 0; k < N; k++) void'(m_q.pop_front());
            m_vis = 1'b0;
            m_idx = 0;
        end
        if (start) begin
            m_vis = 1'b1;
            m_idx = 0;
        end
    endfunction

    function automatic void model_check();
        logic [DW-1:0] ed;
        chk("wr_ready", 32'(wr_ready), 32'(tiles() < 2));
        chk("rd_valid", 32'(rd_valid), 32'(m_vis));
        chk("rd_row_idx", 32'(rd_row_idx), m_vis ? 32'(m_idx) : 32'd0);
        chk("rd_last", 32'(rd_last), 32'(m_vis && m_idx == ROWS - 1));
        for (int c = 0; c < COLS; c++) begin
            ed = m_vis ? m_q[m_idx * COLS + c] : '0;
            chk("rd_row_data", 32'(rd_row_data[c]), 32'(ed));
        end
        chk("err", 32'(err), 32'(m_err));
    endfunction

    function automatic vec_t mk(input bit en, input int row, input int col, input logic [DW-1:0] data,
                                input bit acc, input bit commit, input bit rdy);
        vec_t v;
        v        = '0;
        v.en     = en;
        v.row    = FW'(row);
        v.col    = WW'(col);
        v.data   = data;
        v.acc    = acc;
        v.commit = commit;
        v.rdy    = rdy;
        return v;
    endfunction

    // Attach expected post-edge outputs; prow < 0 means all-zero row data.
    function automatic vec_t ex(input vec_t v, input bit wrr, input bit valid, input int idx,
                                input bit last, input int prow, input bit e);
        vec_t o;
        o            = v;
        o.chk        = 1'b1;
        o.e_wr_ready = wrr;
        o.e_valid    = valid;
        o.e_idx      = FW'(idx);
        o.e_last     = last;
        o.e_err      = e;
        for (int c = 0; c < COLS; c++) o.e_d[c] = (prow < 0) ? '0 : DW'(prow * 16 + c);
        return o;
    endfunction

    task automatic cyc(input vec_t v);
        @(negedge clk);
        wr_en     = v.en;
        wr_row    = v.row;
        wr_col    = v.col;
        wr_data   = v.data;
        wr_accum  = v.acc;
        wr_commit = v.commit;
        rd_ready  = v.rdy;
        @(posedge clk);
        model_update(v);
        #1;
        model_check();
        if (v.chk) begin
            chk("tbl_wr_ready", 32'(wr_ready), 32'(v.e_wr_ready));
            chk("tbl_rd_valid", 32'(rd_valid), 32'(v.e_valid));
            chk("tbl_rd_row_idx", 32'(rd_row_idx), 32'(v.e_idx));
            chk("tbl_rd_last", 32'(rd_last), 32'(v.e_last));
            for (int c = 0; c < COLS; c++) chk("tbl_rd_row_data", 32'(rd_row_data[c]), 32'(v.e_d[c]));
            chk("tbl_err", 32'(err), 32'(v.e_err));
        end
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
        wr_accum = 1'b0; wr_commit = 1'b0; rd_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_idle(input int n, input bit rdy);
        for (int k = 0; k < n; k++) cyc(mk(0, 0, 0, '0, 0, 0, rdy));
    endtask

    vec_t tbl [$];

    initial begin
        int r, c;
        logic [DW-1:0] d;
        rst = 1'b1;
        idle_inputs();
        model_reset();

        // Directed table: fill bank 0 with r*16+c, commit, stream with a 4-cycle stall on row 3.
        for (int i = 0; i < N; i++)
            tbl.push_back(ex(mk(1, i / COLS, i % COLS, DW'((i / COLS) * 16 + (i % COLS)), 0, 0, 0),
                             1, 0, 0, 0, -1, 0));
        tbl.push_back(ex(mk(0, 0, 0, '0, 0, 1, 0), 1, 0, 0, 0, -1, 0));
        tbl.push_back(ex(mk(0, 0, 0, '0, 0, 0, 0), 1, 1, 0, 0, 0, 0));
        tbl.push_back(ex(mk(0, 0, 0, '0, 0, 0, 1), 1, 1, 1, 0, 1, 0));
        tbl.push_back(ex(mk(0, 0, 0, '0, 0, 0, 1), 1, 1, 2, 0, 2, 0));
        tbl.push_back(ex(mk(0, 0, 0, '0, 0, 0, 1), 1, 1, 3, 0, 3, 0));
        for (int k = 0; k < 4; k++)
            tbl.push_back(ex(mk(0, 0, 0, '0, 0, 0, 0), 1, 1, 3, 0, 3, 0));
        tbl.push_back(ex(mk(0, 0, 0, '0, 0, 0, 1), 1, 1, 4, 0, 4, 0));
        tbl.push_back(ex(mk(0, 0, 0, '0, 0, 0, 1), 1, 1, 5, 1, 5, 0));
        tbl.push_back(ex(mk(0, 0, 0, '0, 0, 0, 1), 1, 0, 0, 0, -1, 0));
        tbl.push_back(ex(mk(0, 0, 0, '0, 0, 0, 1), 1, 0, 0, 0, -1, 0));

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_wr_ready", 32'(wr_ready), 32'd1);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_rd_row_idx", 32'(rd_row_idx), 32'd0);
        chk("reset_rd_last", 32'(rd_last), 32'd0);
        chk("reset_rd_row_data0", 32'(rd_row_data[0]), 32'd0);
        chk("reset_err", 32'(err), 32'd0);

        foreach (tbl[i]) cyc(tbl[i]);

        // Both banks full: wr_ready low, dropped write flags err and leaves data intact.
        for (int i = 0; i < N; i++) cyc(mk(1, i / COLS, i % COLS, DW'(16'h0100 + i), 0, 0, 0));
        cyc(mk(0, 0, 0, '0, 0, 1, 0));
        for (int i = 0; i < N; i++) cyc(mk(1, i / COLS, i % COLS, DW'(16'h0200 + i), 0, 0, 0));
        cyc(mk(0, 0, 0, '0, 0, 1, 0));
        chk("full_wr_ready", 32'(wr_ready), 32'd0);
        chk("full_err_clean", 32'(err), 32'd0);
        cyc(mk(1, 0, 0, 16'hDEAD, 0, 0, 0));
        chk("full_drop_err", 32'(err), 32'd1);
        chk("full_drop_data", 32'(rd_row_data[0]), 32'h0100);
        run_idle(6, 1);
        chk("drain_wr_ready", 32'(wr_ready), 32'd1);
        chk("bubble_rd_valid", 32'(rd_valid), 32'd0);
        run_idle(1, 1);
        chk("bank_b_valid", 32'(rd_valid), 32'd1);
        chk("bank_b_row0", 32'(rd_row_data[0]), 32'h0200);
        run_idle(6, 1);

        // Accumulate into a bank that was drained (cleared) earlier.
        do_reset();
        cyc(mk(1, 1, 1, 16'd99, 0, 0, 0));
        cyc(mk(0, 0, 0, '0, 0, 1, 0));
        cyc(mk(0, 0, 0, '0, 0, 1, 0));
        run_idle(16, 1);
        chk("acc_pre_valid", 32'(rd_valid), 32'd0);
        for (int k = 0; k < 3; k++) cyc(mk(1, 1, 1, 16'h0005, 1, 0, 0));
        cyc(mk(0, 0, 0, '0, 0, 1, 0));
        run_idle(1, 0);
        run_idle(1, 1);
        chk("acc_row_idx", 32'(rd_row_idx), 32'd1);
        chk("acc_sum", 32'(rd_row_data[1]), 32'h000F);
        chk("acc_neighbour", 32'(rd_row_data[0]), 32'd0);
        run_idle(5, 1);
        cyc(mk(1, 6, 0, 16'h0001, 0, 0, 0));
        chk("oor_row_err", 32'(err), 32'd1);
        do_reset();
        cyc(mk(1, 0, 3, 16'h0007, 0, 0, 0));
        chk("oor_col_err", 32'(err), 32'd1);

        // Overflowing accumulate: saturate-and-flag or wrap silently.
        do_reset();
        cyc(mk(1, 0, 0, 16'h7FF0, 0, 0, 0));
        cyc(mk(1, 0, 0, 16'h0020, 1, 0, 0));
        cyc(mk(0, 0, 0, '0, 0, 1, 0));
        run_idle(1, 0);
`ifdef FM_WM_SAT_EN
        chk("ovf_data", 32'(rd_row_data[0]), 32'h7FFF);
        chk("ovf_err", 32'(err), 32'd1);
`else
        chk("ovf_data", 32'(rd_row_data[0]), 32'h8010);
        chk("ovf_err", 32'(err), 32'd0);
`endif
        run_idle(6, 1);

        // Asynchronous reset mid-stream wipes both banks and the reader.
        do_reset();
        for (int i = 0; i < N; i++) cyc(mk(1, i / COLS, i % COLS, DW'(16'h0300 + i), 0, 0, 0));
        cyc(mk(0, 0, 0, '0, 0, 1, 0));
        for (int i = 0; i < N; i++) cyc(mk(1, i / COLS, i % COLS, DW'(16'h0400 + i), 0, 0, 0));
        cyc(mk(0, 0, 0, '0, 0, 1, 0));
        run_idle(2, 1);
        chk("pre_rst_idx", 32'(rd_row_idx), 32'd2);
        chk("pre_rst_data", 32'(rd_row_data[0]), 32'h0306);
        @(negedge clk);
        #2;
        rst = 1'b1;
        idle_inputs();
        model_reset();
        #1;
        chk("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("mid_rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("mid_rst_rd_row_idx", 32'(rd_row_idx), 32'd0);
        chk("mid_rst_rd_last", 32'(rd_last), 32'd0);
        chk("mid_rst_rd_row_data0", 32'(rd_row_data[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc(mk(0, 0, 0, '0, 0, 1, 0));
        cyc(mk(0, 0, 0, '0, 0, 1, 0));
        run_idle(16, 1);

        // Random traffic against the model.
        for (int round = 0; round < 3; round++) begin
            do_reset();
            for (int k = 0; k < 500; k++) begin
                r = ($urandom % 16 == 0) ? 6 + int'($urandom % 2) : int'($urandom % ROWS);
                c = ($urandom % 16 == 0) ? 3 : int'($urandom % COLS);
                case ($urandom % 3)
                    0: d = DW'($urandom);
                    1: d = DW'(16'h7F00 + ($urandom % 256));
                    default: d = DW'(16'h8000 + ($urandom % 256));
                endcase
                cyc(mk(($urandom % 3) != 0, r, c, d, ($urandom % 2) != 0,
                       ($urandom % 12) == 0, ($urandom % 4) != 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fm_wm_pingpong_buffer.md
Name: fm_wm_pingpong_buffer

Overview:
Double-buffered (ping-pong) storage for FEATURE_ROWS x WEIGHT_COLS dot-product results.
- A producer (systolic/MAC array) writes or accumulates entries into the write bank. It then commits the bank.
- A sequencer streams the committed bank row by row over a valid/ready interface to the next layer stage.
- Both banks operate concurrently, so the next tile is computed while the previous one drains.

Parameters:
FEATURE_ROWS, 6, rows per bank
WEIGHT_COLS, 3, columns per bank (elements per streamed row)
DOT_PROD_WIDTH, 16, entry width in bits, two's complement
FEATURE_WIDTH, $clog2(FEATURE_ROWS), row index width
WEIGHT_WIDTH, $clog2(WEIGHT_COLS), column index width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
wr_en  in  1  write strobe
wr_row  in  FEATURE_WIDTH  target row
wr_col  in  WEIGHT_WIDTH  target column
wr_data  in  DOT_PROD_WIDTH  write/accumulate operand
wr_accum  in  1  1: entry <= entry + wr_data; 0: entry <= wr_data
wr_commit  in  1  pulse: current write bank complete, hand to reader
wr_ready  out  1  write bank is EMPTY and accepts writes/commit
rd_valid  out  1  rd_row_data valid
rd_ready  in  1  consumer accepts current row
rd_row_idx  out  FEATURE_WIDTH  index of row presented
rd_row_data  out  DOT_PROD_WIDTH x [0:WEIGHT_COLS-1]  unpacked row
rd_last  out  1  high with rd_valid on row FEATURE_ROWS-1
err  out  1  sticky protocol/overflow error, cleared only by rst

Behaviour:
- Reset (async, rst high):
  - All entries of both banks = 0; both banks EMPTY; wr_bank = 0; rd_bank = 0.
  - Read FSM = IDLE; rd_valid = 0, rd_row_idx = 0, rd_last = 0, rd_row_data = 0.
  - wr_ready = 1; err = 0.
  - rst mid-stream or mid-tile aborts everything; no partial state survives.
- Write side:
  - wr_ready = (bank[wr_bank] == EMPTY), combinational from state flops.
  - Write/accumulate completes in one cycle at the clock edge.
  - wr_en with wr_ready=0 is dropped and sets err.
  - wr_en with wr_row >= FEATURE_ROWS or wr_col >= WEIGHT_COLS is dropped and sets err.
  - Accumulate default: sum wraps modulo 2^DOT_PROD_WIDTH.
  - wr_commit with wr_ready=1: bank[wr_bank] <= FULL and wr_bank toggles at the same edge.
  - wr_commit with wr_ready=0 is ignored and sets err.
  - wr_en and wr_commit in the same cycle: the write lands in the bank being committed.
- Read FSM, states IDLE and STREAM:
  - IDLE:
    - rd_valid = 0.
    - If bank[rd_bank] == FULL: go to STREAM at the next edge with rd_row_idx = 0.
    - Commit at edge E gives rd_valid = 1 after edge E+1.
  - STREAM:
    - rd_valid = 1; rd_row_data = mem[rd_bank][rd_row_idx] (from flops, no extra latency).
    - rd_last = (rd_row_idx == FEATURE_ROWS-1).
    - rd_valid, rd_row_idx and rd_row_data stay stable while rd_ready = 0.
    - On rd_valid & rd_ready with rd_last = 0: rd_row_idx++.
    - On rd_valid & rd_ready with rd_last = 1, all at one edge:
      - bank[rd_bank] <= EMPTY and all of its entries cleared to 0, so the next tile accumulates from 0.
      - rd_bank toggles; rd_row_idx <= 0; FSM goes to IDLE.
  - Back-to-back banks: one IDLE bubble cycle between the last row of bank A and row 0 of bank B.
- Concurrency:
  - The read-done clear and a write always target different banks, since the write bank must be EMPTY and the read bank FULL.
  - Both banks FULL: wr_ready = 0 until the reader drains one.
  - Read bank FULL and wr_bank freed in the same cycle as the reader empties: wr_ready rises the cycle after that edge.

Optional Feature:
- Macro FM_WM_SAT_EN.
- Defined: accumulate saturates signed to [-2^(DOT_PROD_WIDTH-1), 2^(DOT_PROD_WIDTH-1)-1]. Any clamp sets err.
- Undefined: wrap-around accumulate; overflow is not flagged.
- Plain writes (wr_accum=0) are identical in both builds.

Test Plan:
- Reset, then write entry (r,c) = r*16+c for all 18 entries, then commit -> wr_ready drops for 0 cycles (bank1 EMPTY); rd_valid rises one edge after the commit edge; rows 0..5 stream with row 2 = {32,33,34}; rd_last only on row 5.
- Hold rd_ready=0 for 4 cycles on row 3 -> rd_row_idx=3 and data held stable; rd_ready=1 advances to row 4.
- Fill and commit both banks without reading -> wr_ready=0. An extra wr_en sets err and leaves data unchanged. After bank0 drains, wr_ready=1 and bank1 streams after one bubble.
- Accumulate 0x0005 three times to (1,1) after a drain -> reads 0x000F (bank cleared to 0 first).
- With FM_WM_SAT_EN: accumulate 0x7FF0 + 0x0020 -> 0x7FFF, err=1. Without the macro -> 0x8010, err=0.
- Assert rst during STREAM at row 2 -> rd_valid=0, both banks EMPTY, all entries 0, wr_ready=1 immediately.
